// File: rtl/acc_pkg.sv
// Shared definitions for the accumulation FIFO bank and its drain controller:
// FSM states, row-counter sizing and flattened-row lane addressing.
package acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } acc_state_t;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int rows_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Bit offset of lane k in a flattened row; lane 0 occupies the MSBs.
    function automatic int lane_lsb(input int k, input int pe_size, input int data_width);
        return (pe_size - 1 - k) * data_width;
    endfunction

endpackage

// File: rtl/acc_drain_lane_op.sv
// Per-lane write-back operator: passthrough, or ReLU when ACC_DRAIN_RELU_EN is defined.
module acc_drain_lane_op #(
    parameter int DATA_WIDTH = 32
) (
    input  logic signed [DATA_WIDTH-1:0] i_lane,
    output logic signed [DATA_WIDTH-1:0] o_lane
);

`ifdef ACC_DRAIN_RELU_EN
    function automatic logic signed [DATA_WIDTH-1:0] relu(input logic signed [DATA_WIDTH-1:0] x);
        return x[DATA_WIDTH-1] ? '0 : x;
    endfunction

    assign o_lane = relu(i_lane);
`else
    assign o_lane = i_lane;
`endif

endmodule

// File: rtl/acc_drain_ctrl.sv
// Drains the accumulator FIFO bank row by row into consecutive GLB words.
// Optional ReLU on write-back is selected with the ACC_DRAIN_RELU_EN macro.
module acc_drain_ctrl
    import acc_pkg::*;
#(
    parameter int PE_SIZE    = 16,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start_i,
    input  logic [rows_cnt_w(FIFO_DEPTH)-1:0]     rows_i,
    input  logic [ADDR_WIDTH-1:0]                 base_addr_i,
    output logic [PE_SIZE-1:0]                    rden_o,
    input  logic [DATA_WIDTH*PE_SIZE-1:0]         psum_row_i,
    input  logic [PE_SIZE-1:0]                    rd_finish_i,
    output logic                                  glb_wren_o,
    input  logic                                  glb_ready_i,
    output logic [ADDR_WIDTH-1:0]                 glb_addr_o,
    output logic [DATA_WIDTH*PE_SIZE-1:0]         glb_wdata_o,
    output logic                                  busy_o,
    output logic                                  done_o,
    output logic                                  underrun_o
);

    localparam int                ROWS_W     = rows_cnt_w(FIFO_DEPTH);
    localparam logic [ROWS_W-1:0] DEPTH_ROWS = ROWS_W'(FIFO_DEPTH);

    acc_state_t                    r_state;
    logic [ROWS_W-1:0]             r_remaining;
    logic [ADDR_WIDTH-1:0]         r_next_addr;
    logic                          r_busy;
    logic                          r_done;
    logic                          r_underrun;

    logic                          r_out_valid;
    logic [ADDR_WIDTH-1:0]         r_out_addr;
    logic [DATA_WIDTH*PE_SIZE-1:0] r_out_data;

    logic                          w_can_accept;
    logic                          w_rd;
    logic                          w_hit_empty;
    logic                          w_last;
    logic [ROWS_W-1:0]             w_rows_clamped;
    logic [DATA_WIDTH*PE_SIZE-1:0] w_row_op;

    for (genvar k = 0; k < PE_SIZE; k++) begin : g_lane
        localparam int LSB = lane_lsb(k, PE_SIZE, DATA_WIDTH);

        acc_drain_lane_op #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lane_op (
            .i_lane (psum_row_i[LSB +: DATA_WIDTH]),
            .o_lane (w_row_op[LSB +: DATA_WIDTH])
        );
    end

    // A read is only issued when the output register is free this cycle, so
    // back-pressure stalls the bank combinationally and no row is lost.
    assign w_can_accept   = !r_out_valid || glb_ready_i;
    assign w_rd           = (r_state == DRAIN) && w_can_accept;
    assign w_hit_empty    = |rd_finish_i;
    assign w_last         = (r_remaining == ROWS_W'(1));
    assign w_rows_clamped = (rows_i > DEPTH_ROWS) ? DEPTH_ROWS : rows_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_next_addr <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_remaining <= w_rows_clamped;
                        r_next_addr <= base_addr_i;
                        r_underrun  <= 1'b0;
                        r_busy      <= 1'b1;
                        if (w_rows_clamped == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_rd) begin
                        r_next_addr <= r_next_addr + ADDR_WIDTH'(1);
                        r_remaining <= r_remaining - ROWS_W'(1);
                        if (w_hit_empty) begin
                            r_underrun <= 1'b1;
                        end
                        // An empty-FIFO read abandons the rest of the drain.
                        if (w_hit_empty || w_last) begin
                            r_state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (!r_out_valid || glb_ready_i) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
        end else if (w_rd) begin
            r_out_valid <= 1'b1;
            r_out_addr  <= r_next_addr;
            r_out_data  <= w_row_op;
        end else if (glb_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    assign rden_o      = {PE_SIZE{w_rd}};
    assign glb_wren_o  = r_out_valid;
    assign glb_addr_o  = r_out_addr;
    assign glb_wdata_o = r_out_data;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign underrun_o  = r_underrun;

endmodule

// File: tb/tb_acc_drain_ctrl.sv
// Self-checking bench for acc_drain_ctrl against a transaction-level drain model.
module tb_acc_drain_ctrl;

    localparam int PE = 16;
    localparam int DW = 32;
    localparam int FD = 16;
    localparam int AW = 12;
    localparam int RW = $clog2(FD + 1);
    localparam int NO_UNDERRUN = 99;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_i;
    logic [RW-1:0]     rows_i;
    logic [AW-1:0]     base_addr_i;
    logic [PE-1:0]     rden_o;
    logic [DW*PE-1:0]  psum_row_i;
    logic [PE-1:0]     rd_finish_i;
    logic              glb_wren_o;
    logic              glb_ready_i;
    logic [AW-1:0]     glb_addr_o;
    logic [DW*PE-1:0]  glb_wdata_o;
    logic              busy_o;
    logic              done_o;
    logic              underrun_o;

    int total = 0;
    int bad   = 0;

    logic [DW*PE-1:0] bank [FD];
    int               rmode;

    acc_drain_ctrl #(
        .PE_SIZE    (PE),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (FD),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .rows_i      (rows_i),
        .base_addr_i (base_addr_i),
        .rden_o      (rden_o),
        .psum_row_i  (psum_row_i),
        .rd_finish_i (rd_finish_i),
        .glb_wren_o  (glb_wren_o),
        .glb_ready_i (glb_ready_i),
        .glb_addr_o  (glb_addr_o),
        .glb_wdata_o (glb_wdata_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .underrun_o  (underrun_o)
    );

    always #5 clk = ~clk;

    function automatic logic [DW*PE-1:0] expect_row(input logic [DW*PE-1:0] r);
        logic [DW*PE-1:0] o;
        o = r;
`ifdef ACC_DRAIN_RELU_EN
        for (int k = 0; k < PE; k++) begin
            if (r[(PE - 1 - k) * DW + DW - 1]) o[(PE - 1 - k) * DW +: DW] = '0;
        end
`endif
        return o;
    endfunction

    function automatic bit ready_at(input int c);
        case (rmode)
            0:       return 1'b1;
            1:       return !(c == 3 || c == 4);
            default: return $urandom_range(0, 3) != 0;
        endcase
    endfunction

    // fill: 0 random rows, 1 all lanes = 0xA+i, 2 random with lane 0 = 0xFFFFFFF0
    task automatic fill_bank(input int fill);
        for (int i = 0; i < FD; i++) begin
            logic [DW-1:0] v;
            v = DW'(32'hA + i);
            for (int k = 0; k < PE; k++) begin
                bank[i][k * DW +: DW] = (fill == 1) ? v : DW'($urandom);
            end
            if (fill == 2) bank[i][(PE - 1) * DW +: DW] = 32'hFFFF_FFF0;
        end
    endtask

    task automatic run_drain(input string nm, input int rows, input logic [AW-1:0] base,
                             input int mode, input int uat, input int fill, input bit restart);
        int rows_c, k, rd_idx, nreads, ndone, done_cyc, first_rd, first_wr, last_wr;
        int busy_cnt, hold_bad, bp_bad, eq_bad, ur_early;
        logic prev_stall;
        logic [AW-1:0] prev_addr;
        logic [DW*PE-1:0] prev_data;
        logic [AW-1:0] wa[$];
        logic [DW*PE-1:0] wd[$];
        int c;

        rmode  = mode;
        rows_c = (rows > FD) ? FD : rows;
        k      = (uat < rows_c) ? uat + 1 : rows_c;
        fill_bank(fill);
        rd_idx = 0; nreads = 0; ndone = 0; done_cyc = -1; first_rd = -1; first_wr = -1;
        last_wr = -1; busy_cnt = 0; hold_bad = 0; bp_bad = 0; eq_bad = 0; ur_early = 0;
        prev_stall = 1'b0; prev_addr = '0; prev_data = '0;

        c = 0;
        while (c < 400 && !(ndone > 0 && c > done_cyc + 3)) begin
            @(negedge clk);
            start_i     = (c == 0) || (restart && c == 2);
            rows_i      = (c == 0) ? RW'(rows) : RW'($urandom_range(0, FD));
            base_addr_i = (c == 0) ? base : AW'($urandom);
            glb_ready_i = ready_at(c);
            psum_row_i  = bank[(rd_idx < FD) ? rd_idx : 0];
            rd_finish_i = (rd_idx == uat) ? '1 : '0;
            #1;
            if (prev_stall && (glb_addr_o !== prev_addr || glb_wdata_o !== prev_data)) hold_bad++;
            if (rden_o !== '0 && rden_o !== '1) eq_bad++;
            if (glb_wren_o && !glb_ready_i && rden_o[0]) bp_bad++;
            if (c == 1 && underrun_o) ur_early++;
            if (rden_o[0] === 1'b1) begin
                nreads++;
                if (first_rd < 0) first_rd = c;
                rd_idx++;
            end
            if (glb_wren_o && glb_ready_i) begin
                wa.push_back(glb_addr_o);
                wd.push_back(glb_wdata_o);
                if (first_wr < 0) first_wr = c;
                last_wr = c;
            end
            if (done_o) begin ndone++; done_cyc = c; end
            if (busy_o) busy_cnt++;
            prev_stall = glb_wren_o && !glb_ready_i;
            prev_addr  = glb_addr_o;
            prev_data  = glb_wdata_o;
            c++;
        end
        start_i = 1'b0;

        total++;
        if (wa.size() !== k) begin
            bad++; $display("FAIL %s write_count: got %0d want %0d", nm, wa.size(), k);
        end
        for (int i = 0; i < wa.size() && i < k; i++) begin
            logic [AW-1:0] ea;
            ea = base + AW'(i);
            total++;
            if (wa[i] !== ea) begin
                bad++; $display("FAIL %s addr[%0d]: got %0h want %0h", nm, i, wa[i], ea);
            end
            total++;
            if (wd[i] !== expect_row(bank[i])) begin
                bad++; $display("FAIL %s data[%0d]: got %0h want %0h", nm, i, wd[i], expect_row(bank[i]));
            end
        end
        total++;
        if (nreads !== k) begin
            bad++; $display("FAIL %s read_count: got %0d want %0d", nm, nreads, k);
        end
        total++;
        if (ndone !== 1) begin
            bad++; $display("FAIL %s done_pulses: got %0d want 1", nm, ndone);
        end
        total++;
        if (busy_cnt !== done_cyc) begin
            bad++; $display("FAIL %s busy_cycles: got %0d want %0d", nm, busy_cnt, done_cyc);
        end
        total++;
        if (underrun_o !== (uat < rows_c)) begin
            bad++; $display("FAIL %s underrun: got %0b want %0b", nm, underrun_o, (uat < rows_c));
        end
        total++;
        if (hold_bad + bp_bad + eq_bad + ur_early !== 0) begin
            bad++;
            $display("FAIL %s stall_rules: got hold=%0d rden_in_stall=%0d rden_uneq=%0d early_ur=%0d want all 0",
                     nm, hold_bad, bp_bad, eq_bad, ur_early);
        end
        if (k > 0) begin
            total++;
            if (done_cyc !== last_wr + 1) begin
                bad++; $display("FAIL %s done_after_last_write: got %0d want %0d", nm, done_cyc, last_wr + 1);
            end
        end
        if (mode == 0) begin
            total++;
            if (done_cyc !== ((k > 0) ? k + 2 : 1)) begin
                bad++; $display("FAIL %s done_cycle: got %0d want %0d", nm, done_cyc, (k > 0) ? k + 2 : 1);
            end
            if (k > 0) begin
                total++;
                if (first_rd !== 1 || first_wr !== 2) begin
                    bad++; $display("FAIL %s first_rd_wr: got %0d/%0d want 1/2", nm, first_rd, first_wr);
                end
            end
        end
    endtask

    task automatic check_quiet(input string nm);
        total++;
        if ({rden_o, glb_wren_o, glb_addr_o, glb_wdata_o, busy_o, done_o, underrun_o} !== '0) begin
            bad++;
            $display("FAIL %s outputs: got rden=%0h wren=%0b addr=%0h busy=%0b done=%0b ur=%0b want all 0",
                     nm, rden_o, glb_wren_o, glb_addr_o, busy_o, done_o, underrun_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; rows_i = '0; base_addr_i = '0;
        psum_row_i = '0; rd_finish_i = '0; glb_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_quiet("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_quiet("post_reset_idle");
    endtask

    task automatic test_basic();
        run_drain("basic", 4, 12'h010, 0, NO_UNDERRUN, 1, 1'b0);
    endtask

    task automatic test_backpressure();
        run_drain("backpressure", 3, 12'h123, 1, NO_UNDERRUN, 0, 1'b0);
    endtask

    task automatic test_underrun();
        run_drain("underrun", 5, 12'h040, 0, 2, 0, 1'b0);
    endtask

    task automatic test_zero_rows();
        run_drain("zero_rows", 0, 12'h055, 0, NO_UNDERRUN, 0, 1'b0);
    endtask

    task automatic test_wrap();
        run_drain("wrap", 4, 12'hFFE, 0, NO_UNDERRUN, 0, 1'b0);
    endtask

    task automatic test_clamp();
        run_drain("clamp", 20, 12'h300, 0, NO_UNDERRUN, 0, 1'b0);
    endtask

    task automatic test_reset_mid_drain();
        int stray;
        @(negedge clk);
        start_i = 1'b1; rows_i = RW'(6); base_addr_i = 12'h100;
        glb_ready_i = 1'b1; rd_finish_i = '0; psum_row_i = {PE{32'h1234_5678}};
        @(negedge clk);
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (busy_o !== 1'b1 || glb_wren_o !== 1'b1) begin
            bad++; $display("FAIL mid_drain_active: got busy=%0b wren=%0b want 1/1", busy_o, glb_wren_o);
        end
        #1;
        rst = 1'b1;
        #1;
        check_quiet("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (glb_wren_o || rden_o != '0 || busy_o) stray++;
        end
        total++;
        if (stray !== 0) begin
            bad++; $display("FAIL after_reset_activity: got %0d cycles want 0", stray);
        end
        run_drain("after_reset", 2, 12'h2A0, 0, NO_UNDERRUN, 2, 1'b0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            int rows, uat;
            rows = $urandom_range(0, 20);
            uat  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : NO_UNDERRUN;
            run_drain("random", rows, AW'($urandom), 2, uat, 0, (rows > 0) && $urandom_range(0, 1) == 1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_underrun();
        test_zero_rows();
        test_wrap();
        test_clamp();
        test_reset_mid_drain();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/acc_drain_ctrl.md
Name: acc_drain_ctrl

Overview:
Drain/write-back controller on the read side of the accumulation FIFO bank. On a start pulse it issues per-column read enables to the bank and captures each returned partial-sum row. It writes one full row per beat into the global buffer (GLB) at consecutive addresses, honours GLB back-pressure, and reports done and underrun status to top-level dataflow control.

Parameters:
PE_SIZE, 16, number of accumulator columns (one FIFO per column)
DATA_WIDTH, 32, bits per partial sum (two's complement)
FIFO_DEPTH, 16, entries per accumulator FIFO; maximum rows per drain
ADDR_WIDTH, 12, GLB word-address width (one word = one full row)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
start_i  input  1  one-cycle pulse; begin drain (ignored unless IDLE)
rows_i  input  $clog2(FIFO_DEPTH+1)  rows to drain, sampled on accepted start; valid range 0..FIFO_DEPTH
base_addr_i  input  ADDR_WIDTH  first GLB address, sampled on accepted start
rden_o  output  PE_SIZE  read enable to accumulator bank; all bits equal
psum_row_i  input  DATA_WIDTH*PE_SIZE  row data from bank, valid in the same cycle as rden_o; column 0 in MSBs
rd_finish_i  input  PE_SIZE  per-column "read while empty" flags from bank
glb_wren_o  output  1  GLB write valid
glb_ready_i  input  1  GLB accepts the write this cycle
glb_addr_o  output  ADDR_WIDTH  GLB write address
glb_wdata_o  output  DATA_WIDTH*PE_SIZE  GLB write data, same column order as psum_row_i
busy_o  output  1  high in any state other than IDLE
done_o  output  1  one-cycle pulse at end of drain
underrun_o  output  1  sticky; a read hit an empty FIFO during the last drain

Behaviour:
- Reset (asynchronous, any state, including mid-drain): state=IDLE; all outputs 0; counters, output register and address cleared. Nothing is written after reset deasserts until a new start.
- FSM states: IDLE, DRAIN, FLUSH, DONE.
- IDLE: on start_i, latch rows_i to remaining and base_addr_i to next address, and clear underrun_o.
  - rows_i==0: go to DONE (no reads, no writes).
  - Otherwise: go to DRAIN.
- Output register: one stage (out_valid, out_addr, out_data). It can accept a new row when !out_valid || glb_ready_i.
- DRAIN:
  - rden_o = {PE_SIZE{can_accept}}.
  - On each read cycle: load psum_row_i into the output register at the current address, then address+1 and remaining-1.
  - When the read that takes remaining to 0 completes, go to FLUSH.
- Underrun: any rd_finish_i bit high while rden_o is high means underrun.
  - Set underrun_o.
  - That row is still written.
  - Go to FLUSH immediately; the rows still remaining are not read.
- FLUSH: rden_o=0. When out_valid && glb_ready_i (last beat accepted), go to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- glb_wren_o=out_valid. glb_addr_o and glb_wdata_o come from the register and stay stable while glb_wren_o && !glb_ready_i.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap-around is allowed and not flagged.
- Latency with glb_ready_i held high:
  - start in cycle 0.
  - First rden_o in cycle 1; first glb_wren_o in cycle 2.
  - N rows: last glb_wren_o in cycle N+1; done_o in cycle N+2.
- Back-pressure: if glb_ready_i is low while out_valid, rden_o drops in the same cycle. No row is dropped or duplicated.
- start_i while busy_o: ignored, no state change.
- rows_i > FIFO_DEPTH: clamped to FIFO_DEPTH.

Optional Feature:
ACC_DRAIN_RELU_EN.
- Defined: each DATA_WIDTH lane of psum_row_i whose MSB is set is replaced by zero before it enters the output register (ReLU applied on write-back).
- Undefined: data passes through unmodified. No extra logic or ports in either case.

Decomposition:
- Shared package acc_pkg: FSM state enum (IDLE, DRAIN, FLUSH, DONE), the rows-counter width function ($clog2(FIFO_DEPTH+1)), and the helper that extracts lane k from a flattened row (MSB-first ordering). The accumulator bank uses the same package.
- One natural sub-module: acc_drain_lane_op. It is a per-lane DATA_WIDTH passthrough/ReLU, generated PE_SIZE times. Everything else stays in the top.

Test Plan:
- rows_i=4, base_addr_i=0x010, ready always 1, rows 0xA..0xD -> rden_o high in cycles 1-4; writes to 0x010-0x013 with data A..D in cycles 2-5; done_o in cycle 6; underrun_o=0.
- rows_i=3, glb_ready_i low in cycles 3-4 -> rden_o low in those cycles; glb_addr_o/glb_wdata_o held; exactly 3 writes at base..base+2; done_o one cycle after the last accepted write.
- rows_i=5, rd_finish_i=all-1 on the 3rd read -> 3 writes; underrun_o=1 until the next start; done_o pulses; no 4th rden_o.
- rows_i=0 -> no rden_o, no glb_wren_o; done_o in cycle 1; busy_o high only in cycle 1.
- base_addr_i=0xFFE, rows_i=4 -> addresses 0xFFE, 0xFFF, 0x000, 0x001.
- rst asserted mid-DRAIN after 2 rows, then a new start with rows_i=2 -> all outputs 0 immediately on reset; second drain writes exactly 2 rows from its own base; with ACC_DRAIN_RELU_EN, input lane 0xFFFFFFF0 is written as 0x00000000.
